// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-through no-write-allocate data cache with word-wide refill controller
module dcache_ctrl #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        i_Clk,
  input  logic        i_Reset_n,
  input  logic        i_Rd,
  input  logic        i_Wr,
  input  logic [31:0] i_Addr,
  input  logic [31:0] i_WData,
  output logic [31:0] o_RData,
  output logic        o_DCache_Miss,
  output logic        o_Mem_Req,
  output logic        o_Mem_We,
  output logic [31:0] o_Mem_Addr,
  output logic [31:0] o_Mem_WData,
  input  logic        i_Mem_Ack,
  input  logic [31:0] i_Mem_RData
);
  localparam int WB = $clog2(WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TW = 30 - WB - IB;
  typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;
  state_t            state;
  logic [LINES-1:0]  valid;
  logic [TW-1:0]     tags [LINES];
  logic [31:0]       data [LINES][WORDS];
  logic [31:0]       addr_q, wdata_q;
  logic [WB-1:0]     cnt;
  logic [WB-1:0]     a_word, q_word;
  logic [IB-1:0]     a_idx, q_idx;
  logic [TW-1:0]     a_tag, q_tag;
  logic              hit, q_hit, last;
  assign a_word = i_Addr[2+:WB];
  assign a_idx  = i_Addr[2+WB+:IB];
  assign a_tag  = i_Addr[31-:TW];
  assign q_word = addr_q[2+:WB];
  assign q_idx  = addr_q[2+WB+:IB];
  assign q_tag  = addr_q[31-:TW];
  assign hit    = valid[a_idx] && tags[a_idx] == a_tag;
  assign q_hit  = valid[q_idx] && tags[q_idx] == q_tag;
  assign last   = cnt == WB'(WORDS - 1);
  assign o_DCache_Miss = i_Reset_n && (state == REFILL || state == WRITE ||
                         (state == IDLE && (i_Wr || (i_Rd && !hit))));
  assign o_RData     = (state == IDLE || state == DONE) && i_Rd && hit ? data[a_idx][a_word] : '0;
  assign o_Mem_Req   = state == REFILL || state == WRITE;
  assign o_Mem_We    = state == WRITE;
  assign o_Mem_Addr  = state == REFILL ? {addr_q[31:2+WB], cnt, 2'b00} :
                       state == WRITE  ? {addr_q[31:2], 2'b00} : '0;
  assign o_Mem_WData = state == WRITE ? wdata_q : '0;
  always_ff @(posedge i_Clk or negedge i_Reset_n)
    if (!i_Reset_n) begin
      state   <= IDLE;
      valid   <= '0;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else
      case (state)
        IDLE:
          if (i_Wr) begin
            addr_q  <= i_Addr;
            wdata_q <= i_WData;
            state   <= WRITE;
          end else if (i_Rd && !hit) begin
            // line stays invalid until its last word lands, so a partial refill never hits
            addr_q       <= {i_Addr[31:2+WB], {(WB+2){1'b0}}};
            cnt          <= '0;
            valid[a_idx] <= 1'b0;
            state        <= REFILL;
          end
        REFILL:
          if (i_Mem_Ack) begin
            cnt <= cnt + 1'b1;
            if (last) begin
              valid[q_idx] <= 1'b1;
              state        <= DONE;
            end
          end
        WRITE:   state <= i_Mem_Ack ? DONE : WRITE;
        default: state <= IDLE;
      endcase
  always_ff @(posedge i_Clk) begin
    if (state == REFILL && i_Mem_Ack) data[q_idx][cnt] <= i_Mem_RData;
    if (state == REFILL && i_Mem_Ack && last) tags[q_idx] <= q_tag;
    if (state == WRITE && i_Mem_Ack && q_hit) data[q_idx][q_word] <= wdata_q;
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed and random accesses checked against a line-residency and memory-contents model
module tb_dcache_ctrl;
  logic        i_Clk = 0, i_Reset_n = 0, i_Rd = 0, i_Wr = 0, i_Mem_Ack = 0;
  logic [31:0] i_Addr = 0, i_WData = 0, i_Mem_RData = 0;
  logic [31:0] o_RData, o_Mem_Addr, o_Mem_WData;
  logic        o_DCache_Miss, o_Mem_Req, o_Mem_We;
  int total = 0, fails = 0;
  bit [31:0] mem [bit [31:0]];
  int line_tag [16];

  dcache_ctrl dut (
    .i_Clk(i_Clk), .i_Reset_n(i_Reset_n), .i_Rd(i_Rd), .i_Wr(i_Wr),
    .i_Addr(i_Addr), .i_WData(i_WData), .o_RData(o_RData),
    .o_DCache_Miss(o_DCache_Miss), .o_Mem_Req(o_Mem_Req), .o_Mem_We(o_Mem_We),
    .o_Mem_Addr(o_Mem_Addr), .o_Mem_WData(o_Mem_WData),
    .i_Mem_Ack(i_Mem_Ack), .i_Mem_RData(i_Mem_RData)
  );

  always #5 i_Clk = ~i_Clk;

  function automatic bit [31:0] mval(bit [31:0] a);
    bit [31:0] w = a & ~32'h3;
    return mem.exists(w) ? mem[w] : (w * 32'h9E3779B1) ^ 32'hA5A50000;
  endfunction

  function automatic int lidx(bit [31:0] a);
    return int'((a >> 4) & 32'hF);
  endfunction

  function automatic bit resident(bit [31:0] a);
    return line_tag[lidx(a)] == int'(a >> 8);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) line_tag[i] = -1;
  endtask

  // mode 0: ack every request cycle, 1: ack every other cycle, 2: random acks
  task automatic access(bit rd, bit wr, bit [31:0] a, bit [31:0] wd, int mode, int abort_at);
    bit hit, exp_miss, ack;
    int stalls, acks, gaps, need;
    bit [31:0] base;
    hit      = resident(a);
    exp_miss = wr || (rd && !hit);
    need     = wr ? 1 : 4;
    base     = a & ~32'hF;
    i_Rd = rd; i_Wr = wr; i_Addr = a; i_WData = wd;
    @(negedge i_Clk);
    chk("miss_same_cycle", 32'(o_DCache_Miss), 32'(exp_miss));
    if (rd && !exp_miss) chk("hit_rdata", o_RData, mval(a));
    if (exp_miss) begin
      chk("req_cycle0", 32'(o_Mem_Req), 0);
      stalls = 0; acks = 0; gaps = 0;
      while (o_DCache_Miss && stalls < 300) begin
        stalls++;
        if (o_Mem_Req) begin
          if (acks == abort_at) begin
            i_Reset_n = 0;
            #1;
            chk("rst_req", 32'(o_Mem_Req), 0);
            chk("rst_miss", 32'(o_DCache_Miss), 0);
            chk("rst_addr", o_Mem_Addr, 0);
            chk("rst_rdata", o_RData, 0);
            clear_model();
            @(posedge i_Clk);
            #1 i_Reset_n = 1; i_Rd = 0; i_Wr = 0;
            return;
          end
          chk("mem_we", 32'(o_Mem_We), 32'(wr));
          chk("mem_addr", o_Mem_Addr, wr ? (a & ~32'h3) : base + 32'(4 * acks));
          if (wr) chk("mem_wdata", o_Mem_WData, wd);
          ack = mode == 0 ? 1'b1 : mode == 1 ? (stalls % 2 == 1) : ($urandom % 3 != 0);
          i_Mem_RData = (ack && !wr) ? mval(base + 32'(4 * acks)) : $urandom;
          i_Mem_Ack = ack;
          if (ack) acks++; else gaps++;
        end
        @(posedge i_Clk);
        #1 i_Mem_Ack = 0;
        @(negedge i_Clk);
      end
      chk("stall_cycles", 32'(stalls), 32'(1 + need + gaps));
      chk("done_no_req", 32'(o_Mem_Req), 0);
      if (wr) mem[a & ~32'h3] = wd;
      else begin
        line_tag[lidx(a)] = int'(a >> 8);
        chk("done_rdata", o_RData, mval(a));
      end
    end
    @(posedge i_Clk);
    #1 i_Rd = 0; i_Wr = 0;
  endtask

  initial begin
    clear_model();
    @(negedge i_Clk);
    chk("reset_miss", 32'(o_DCache_Miss), 0);
    chk("reset_req", 32'(o_Mem_Req), 0);
    chk("reset_we", 32'(o_Mem_We), 0);
    chk("reset_addr", o_Mem_Addr, 0);
    chk("reset_wdata", o_Mem_WData, 0);
    chk("reset_rdata", o_RData, 0);
    @(posedge i_Clk);
    #1 i_Reset_n = 1;
    access(1, 0, 32'h100, 0, 0, -1);
    access(1, 0, 32'h108, 0, 0, -1);
    access(1, 0, 32'h140, 0, 1, -1);
    access(0, 1, 32'h104, 32'hDEADBEEF, 0, -1);
    access(1, 0, 32'h104, 0, 0, -1);
    chk("store_hit_data", mval(32'h104), 32'hDEADBEEF);
    access(0, 1, 32'h2000, 32'hCAFEF00D, 0, -1);
    access(1, 0, 32'h2000, 0, 0, -1);
    access(1, 0, 32'h500, 0, 0, -1);
    access(1, 0, 32'h100, 0, 0, -1);
    access(1, 0, 32'h500, 0, 0, -1);
    access(1, 0, 32'h100, 0, 0, 2);
    access(1, 0, 32'h100, 0, 0, -1);
    access(1, 1, 32'h104, 32'h12345678, 0, -1);
    i_Mem_Ack = 1;
    @(negedge i_Clk);
    chk("spurious_req", 32'(o_Mem_Req), 0);
    chk("spurious_miss", 32'(o_DCache_Miss), 0);
    @(posedge i_Clk);
    #1 i_Mem_Ack = 0;
    @(negedge i_Clk);
    chk("spurious_after_req", 32'(o_Mem_Req), 0);
    access(1, 0, 32'h100, 0, 0, -1);
    access(1, 0, 32'h104, 0, 0, -1);
    repeat (60) begin
      bit [31:0] a;
      int op;
      a  = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2);
      op = $urandom_range(0, 3);
      access(op < 2 || op == 3, op >= 2, a, $urandom, $urandom_range(0, 2), -1);
    end
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache with refill controller for the MEM stage. Serves load/store accesses from the EXMA register and drives `o_DCache_Miss` into the stall unit, freezing PC/IFID/IDEX/EXMA and flushing MAWB while a refill or store is outstanding. Cache misses refill from a word-wide memory port, one word per acknowledge.

## Interface

Parameters:
- `LINES`, 16: number of cache lines; power of two.
- `WORDS`, 4: 32-bit words per line; power of two, at least 2.

Ports:
- `i_Clk`, in, 1: clock; all state updates on the rising edge.
- `i_Reset_n`, in, 1: reset, asynchronous, active-low.
- `i_Rd`, in, 1: load request from EXMA.
- `i_Wr`, in, 1: store request from EXMA; has priority if `i_Rd` is also high.
- `i_Addr`, in, 32: byte address; bits [1:0] ignored.
- `i_WData`, in, 32: store data.
- `o_RData`, out, 32: load data; valid when `i_Rd` is high and `o_DCache_Miss` is 0.
- `o_DCache_Miss`, out, 1: to stall unit; 1 = hold the pipeline.
- `o_Mem_Req`, out, 1: memory request.
- `o_Mem_We`, out, 1: 1 = write, 0 = read.
- `o_Mem_Addr`, out, 32: word-aligned memory address.
- `o_Mem_WData`, out, 32: write data.
- `i_Mem_Ack`, in, 1: memory has accepted the write, or returns `i_Mem_RData` this cycle.
- `i_Mem_RData`, in, 32: read word.

## Operation

Address split:
- Offset: [1:0].
- Word: next log2(WORDS) bits.
- Index: next log2(LINES) bits.
- Tag: the remainder (24 bits at defaults).

Storage:
- Per line: valid bit, tag, WORDS data words.
- Hit = valid[index] & (tag[index] == tag).

States:
- IDLE
  - Neither `i_Rd` nor `i_Wr`: stay, miss = 0.
  - Read hit: `o_RData` = array word (combinational), miss = 0, stay.
  - Read miss: miss = 1; latch line base (tag, index, word = 0) into the address register; go to REFILL.
  - Write (hit or miss): miss = 1; latch `i_Addr`/`i_WData`; go to WRITE.
- REFILL
  - miss = 1; `o_Mem_Req` = 1, `o_Mem_We` = 0, `o_Mem_Addr` = line base + 4*count.
  - On each `i_Mem_Ack`: write `i_Mem_RData` to word[count], then count++.
  - On the ack with count == WORDS-1: set tag and valid for the line; go to DONE.
  - Without an ack, all outputs hold.
- WRITE
  - miss = 1; `o_Mem_Req` = 1, `o_Mem_We` = 1, address/data from the latches.
  - On `i_Mem_Ack`: if the latched address hits, update that cached word (no allocate on a miss); go to DONE.
- DONE
  - miss = 0 for one cycle; no memory request.
  - The held load now hits and `o_RData` is valid; a held store is not reissued.
  - Go to IDLE unconditionally.

Other rules:
- `o_RData` = 0 whenever not (IDLE or DONE) with `i_Rd`.
- `i_Mem_Ack` outside REFILL/WRITE is ignored.
- Word counter width is log2(WORDS); it wraps to 0 on line completion.

## Timing

- Reset (asynchronous, any state, including mid-refill):
  - State goes to IDLE; all valid bits clear; counter = 0.
  - `o_Mem_Req`/`o_Mem_We` = 0, `o_Mem_Addr`/`o_Mem_WData` = 0.
  - `o_DCache_Miss` forced 0 while `i_Reset_n` = 0; `o_RData` = 0.
  - A partial line is never marked valid.
- `o_DCache_Miss` is combinational from state, `i_Rd`/`i_Wr` and the hit compare, so the stall applies in the same cycle as the access.
- Memory outputs come from registered state and latches only, and are stable for the whole request.
- Read hit: 0 stall cycles.
- Read miss with ack every cycle:
  - Cycle 0: miss.
  - Cycles 1..WORDS: REFILL.
  - Cycle WORDS+1: DONE.
  - WORDS+1 stall cycles in total (5 at defaults).
- Store with immediate ack:
  - Cycle 0: IDLE, miss = 1.
  - Cycle 1: WRITE.
  - Cycle 2: DONE.
  - 2 stall cycles.
- `i_Rd` and `i_Wr` together: treated as a store.
- Memory latency is unbounded; the block waits indefinitely with no timeout.

## Test plan

- Reset, then `i_Rd` at 0x100 -> `o_DCache_Miss` = 1 in the same cycle. Four reads at 0x100, 0x104, 0x108, 0x10C, acked back-to-back with data A0..A3 -> DONE on cycle 5 with `o_RData` = A0. A reread at 0x108 -> hit, `o_RData` = A2, miss = 0.
- Refill with ack every other cycle -> `o_Mem_Addr` holds during gaps, miss stays 1 for 9 cycles, then one DONE cycle.
- Store 0xDEADBEEF to 0x104 after the line is resident -> one write request (`o_Mem_We` = 1, address 0x104) and 2 stall cycles; a later load at 0x104 hits and returns 0xDEADBEEF. Store to 0x2000 (miss) -> memory write only; a later load at 0x2000 misses.
- Conflict at 0x100 versus 0x500 (same index, different tag) -> a load at 0x500 refills and evicts; a load at 0x100 then misses again.
- `i_Reset_n` pulsed low after two refill acks -> immediate IDLE with `o_Mem_Req` = 0; a load at 0x100 after reset misses and refills the full line from word 0.
- `i_Rd` and `i_Wr` both high at 0x104 -> write request issued with no refill; spurious `i_Mem_Ack` in IDLE -> no state change.
